wb_uart_tx: RTL

Memory-mapped UART transmitter that responds on the hart's Wishbone data bus, alongside `block_ram`. It accepts the same pipelined stb/we/sel/addr/data requests and returns ack/stall/data. Bytes written to its data register are buffered in a FIFO and serialised as 8N1 frames on `o_tx`. Compliance and firmware code use it to emit characters without blocking the core unless the FIFO is full.

---
 rtl/wb_uart_tx.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone-mapped 8N1 UART transmitter with a TX FIFO and a
// programmable bit-period divisor (bit period = DIV+1 clock cycles).
module wb_uart_tx #(
  parameter int          XLEN        = 32,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_stb,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic            i_wb_we,
  input  logic [2:0]      i_wb_sel,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic            o_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;  // count field must fit STATUS[15:8]

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Bus-side state
  logic            ack_q, ack_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [15:0]     div_q, div_d;

  // FIFO state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Transmit FSM state
  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;

  logic [1:0] reg_sel;
  logic       full, empty, busy;
  logic       accept, push, pop;
  logic [7:0] fifo_rd;

  // Address bits below the word offset and above the map, and the upper
  // data byte lanes, carry no meaning for this peripheral.
  logic unused_bits;
  assign unused_bits = ^{i_addr[XLEN-1:4], i_addr[1:0], i_data[XLEN-1:16]};

  assign reg_sel = i_addr[3:2];
  // full comes from the registered count, so a pop this cycle cannot lift
  // the stall until the following cycle.
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign busy    = (state_q != ST_IDLE);
  assign fifo_rd = mem[rd_ptr_q];

  assign o_wb_stall = i_wb_stb & i_wb_we & (reg_sel == REG_TXDATA) & full;
  assign accept     = i_wb_stb & ~o_wb_stall;
  assign push       = accept & i_wb_we & (reg_sel == REG_TXDATA);

  assign o_wb_ack  = ack_q;
  assign o_wb_data = rdata_q;
  assign o_tx      = tx_q;

  // Bus response, divisor register and FIFO bookkeeping next-state.
  always_comb begin
    // NOTE: every signal gets a default at the top of a combinational block,
    // so no path leaves it unassigned and no latch is inferred.
    ack_d    = accept;
    rdata_d  = '0;
    div_d    = div_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (accept && !i_wb_we) begin
      unique case (reg_sel)
        REG_STATUS: begin
          rdata_d[0]      = full;
          rdata_d[1]      = empty;
          rdata_d[2]      = busy;
          rdata_d[8 +: CW] = count_q;
        end
        REG_DIV:    rdata_d[15:0] = div_q;
        default:    rdata_d = '0;
      endcase
    end

    if (accept && i_wb_we && reg_sel == REG_DIV) begin
      if (i_wb_sel == 3'b000) div_d[7:0] = i_data[7:0];
      else                    div_d      = i_data[15:0];
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Bus and FIFO control registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (i_reset) begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      div_q    <= DEFAULT_DIV;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      div_q    <= div_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge i_clk) begin
    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so clearing the data buys nothing.
    if (push) mem[wr_ptr_q] <= i_data[7:0];
  end

  // Transmit FSM next-state: counter reloads from the live divisor at each
  // bit boundary, and STOP chains straight into START when data is waiting.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd;
          cnt_d   = div_q;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd;
            cnt_d   = div_q;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered so o_tx stays registered.
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Transmit FSM registers, including the registered serial output.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

endmodule
